// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared md_op encoding and default multiply/divide latencies.
package e_mdu_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: issue/read bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hl_sel;
  logic [31:0] hl_out;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, src_a, src_b, hl_sel, input hl_out, busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, hl_sel, output hl_out, busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle MULT/DIV unit owning HI/LO; a 4-bit down-counter is the IDLE/RUN state.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave md
);
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, ua, ub, quo, rem, q_res, r_res;
  logic [63:0] prod_s, prod_u;
  logic        issue, is_mul, is_div, done, sgn;
  always_ff @(posedge clk)
    cnt <= reset ? 4'd0 : cnt_nxt;
  always_comb begin
    issue   = md.start && cnt == 4'd0;
    is_mul  = md.md_op == MD_MULT || md.md_op == MD_MULTU;
    is_div  = md.md_op == MD_DIV || md.md_op == MD_DIVU;
    cnt_nxt = issue && is_mul ? 4'(MULT_CYCLES) :
              issue && is_div ? 4'(DIV_CYCLES) :
              cnt != 4'd0     ? cnt - 4'd1 : 4'd0;
    done    = cnt == 4'd1;
  end
  always_comb begin
    md.busy   = cnt != 4'd0;
    md.hl_out = md.hl_sel ? hi_q : lo_q;
    md.hi     = hi_q;
    md.lo     = lo_q;
  end
  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    sgn    = op_q == MD_DIV;
    ua     = sgn && a_q[31] ? -a_q : a_q;
    ub     = sgn && b_q[31] ? -b_q : b_q;
    quo    = ub == 32'd0 ? 32'd0 : ua / ub;
    rem    = ub == 32'd0 ? 32'd0 : ua % ub;
    q_res  = sgn && (a_q[31] ^ b_q[31]) ? -quo : quo;
    r_res  = sgn && a_q[31] ? -rem : rem;
  end
  always_ff @(posedge clk)
    if (issue && (is_mul || is_div)) begin
      a_q  <= md.src_a;
      b_q  <= md.src_b;
      op_q <= md.md_op;
    end
  always_ff @(posedge clk)
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done && (op_q == MD_MULT || op_q == MD_MULTU))
      {hi_q, lo_q} <= op_q == MD_MULT ? prod_s : prod_u;
    else if (done && b_q != 32'd0) begin
      hi_q <= r_res;
      lo_q <= q_res;
    end else if (issue && md.md_op == MD_MTHI)
      hi_q <= md.src_a;
    else if (issue && md.md_op == MD_MTLO)
      lo_q <= md.src_a;
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Sits beside the ALU in E and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations and handles MTHI/MTLO.
- Drives the HI/LO read value that the E/M pipeline register captures for MFHI/MFLO.
- Exports busy so the hazard unit can stall later HI/LO users.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, 10, number of busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  issue strobe; high for one cycle with a valid md_op in E
- md_op  input  3  operation code (shared-package encoding)
- src_a  input  32  forwarded rs value
- src_b  input  32  forwarded rt value
- hl_sel  input  1  read select: 1 = HI, 0 = LO
- hl_out  output  32  combinational read of HI or LO, per hl_sel
- busy  output  1  multi-cycle operation in progress
- hi  output  32  HI register (debug/visibility)
- lo  output  32  LO register (debug/visibility)

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high on port reset, sampled at posedge clk.
  - On reset: HI=0, LO=0, busy=0, counter=0, pending result discarded.
  - Reset overrides everything, including an operation in flight.
- States:
  - IDLE (busy=0) and RUN (busy=1).
  - The state is held by a 4-bit down-counter; RUN means counter != 0.
- Issue in IDLE (start=1 at cycle T):
  - MULT/MULTU/DIV/DIVU: latch src_a and src_b; load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 for cycles T+1 .. T+N.
  - HI/LO take the result at the posedge ending cycle T+N, so they are visible from T+N+1.
  - busy=0 in cycle T+N+1.
- MTHI/MTLO:
  - Write src_a into HI or LO at the posedge ending the issue cycle.
  - busy stays 0; the other register is unchanged.
- NONE, or unused codes 7..: no effect.
- start while busy=1: ignored entirely. The operation in flight and HI/LO are untouched. The hazard unit must stall any md instruction in E while busy or start; ignoring start here is defensive only.
- start with md_op=NONE: no effect.
- Arithmetic (the result is a function only of the operands latched at issue):
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Divide by zero (DIV or DIVU): busy timing unchanged; HI and LO keep their prior values.
- hl_out:
  - Purely combinational from the current HI/LO registers.
  - No bypass of a same-cycle MTHI/MTLO or of an in-flight result.
  - Readers must be stalled while busy.
- Back-to-back: a new start is accepted in the cycle busy falls (T+N+1); its result completes at T+N+1+N'.

Decomposition:
- Shared package:
  - md_op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default cycle counts, reused by the hazard unit and the decoder.
- No sub-module. Counter, operand latches and result datapath stay in one block of roughly 150 lines.

Test Plan:
- Reset, then start MULT a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; hl_sel=0 gives 0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 afterwards -> HI/LO unchanged after 10 busy cycles.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> busy never asserts; next cycle hl_out=0x12345678 with hl_sel=1 and 0x9ABCDEF0 with hl_sel=0.
- Start DIV; pulse start with MULT at busy cycle 3 -> the MULT is ignored; the DIV result lands at cycle 10 and busy falls on schedule.
- Start MULT; assert reset in busy cycle 2 -> next cycle busy=0 and HI=LO=0; no result is written later.
